// File: rtl/agc_loop_pkg.sv
// AGC loop master shared definitions: register offsets,
// CTRL command words, field widths and FSM states.
package agc_loop_pkg;

  localparam int SQ_W  = 24;
  localparam int GT_W  = 21;
  localparam int SC_W  = 17;
  localparam int OF_W  = 8;
  localparam int ADR_W = 22;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_SQ     = 8'h04;
  localparam logic [7:0] OFF_GT     = 8'h08;
  localparam logic [7:0] OFF_LT     = 8'h0C;
  localparam logic [7:0] OFF_SCALE  = 8'h10;
  localparam logic [7:0] OFF_OFFSET = 8'h14;

  localparam int CTRL_TICK  = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_RST   = 2;
  localparam int CTRL_LD_SC = 8;
  localparam int CTRL_LD_OF = 9;
  localparam int CTRL_APPLY = 10;

  localparam logic [31:0] CMD_TICK = 32'(1) << CTRL_TICK;
  localparam logic [31:0] CMD_RST  = 32'(1) << CTRL_RST;
  localparam logic [31:0] CMD_LOAD = (32'(1) << CTRL_LD_SC)
                                   | (32'(1) << CTRL_LD_OF)
                                   | (32'(1) << CTRL_APPLY);

  typedef enum logic [4:0] {
    S_IDLE,
    S_INIT_RST,
    S_INIT_SCALE,
    S_INIT_OFFSET,
    S_INIT_LOAD,
    S_TICK,
    S_POLL,
    S_POLL_WAIT,
    S_RD_SQ,
    S_RD_GT,
    S_RD_LT,
    S_CALC,
    S_WR_SCALE,
    S_WR_OFFSET,
    S_WR_LOAD,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/agc_loop_calc.sv
// Combinational saturating update of the AGC scale (unsigned)
// and offset (signed) from one set of accumulator readings.
module agc_loop_calc
  import agc_loop_pkg::*;
#(
  parameter logic [SC_W-1:0] SCALE_STEP = 17'h00100
) (
  input  logic [SQ_W-1:0] sq_i,
  input  logic [SQ_W-1:0] sq_target_i,
  input  logic [SQ_W-1:0] sq_window_i,
  input  logic [GT_W-1:0] gt_i,
  input  logic [GT_W-1:0] lt_i,
  input  logic [GT_W-1:0] deadband_i,
  input  logic [SC_W-1:0] scale_i,
  input  logic [OF_W-1:0] offset_i,
  output logic [SC_W-1:0] scale_o,
  output logic [OF_W-1:0] offset_o
);

  logic [SQ_W:0] sq25;
  logic [SQ_W:0] hi_thr;
  logic [SQ_W:0] lo_thr;
  logic [SC_W:0] sc_sum;
  logic [GT_W:0] gt22;
  logic [GT_W:0] lt22;
  logic [GT_W:0] gt_lim;
  logic [GT_W:0] lt_lim;

  assign sq25   = {1'b0, sq_i};
  assign hi_thr = {1'b0, sq_target_i} + {1'b0, sq_window_i};
  assign lo_thr = (sq_target_i > sq_window_i)
                ? {1'b0, sq_target_i - sq_window_i}
                : '0;
  assign sc_sum = {1'b0, scale_i} + {1'b0, SCALE_STEP};

  assign gt22   = {1'b0, gt_i};
  assign lt22   = {1'b0, lt_i};
  assign gt_lim = gt22 + {1'b0, deadband_i};
  assign lt_lim = lt22 + {1'b0, deadband_i};

  always_comb begin
    scale_o = scale_i;
    if (sq25 > hi_thr) begin
      scale_o = (scale_i > SCALE_STEP) ? scale_i - SCALE_STEP : '0;
    end else if (sq25 < lo_thr) begin
      scale_o = sc_sum[SC_W] ? '1 : sc_sum[SC_W-1:0];
    end
  end

  // 0x80 / 0x7F are the signed 8-bit rails
  always_comb begin
    offset_o = offset_i;
    if (gt22 > lt_lim) begin
      if (offset_i != 8'h80) offset_o = offset_i - 8'd1;
    end else if (lt22 > gt_lim) begin
      if (offset_i != 8'h7F) offset_o = offset_i + 8'd1;
    end
  end

endmodule

// File: rtl/agc_loop_master.sv
// Wishbone initiator running the AGC tick/poll/read/update loop.
// Optional ack watchdog: define AGC_LOOP_ACK_TIMEOUT_EN.
module agc_loop_master
  import agc_loop_pkg::*;
#(
  parameter logic [ADR_W-1:0] BASE_ADDR   = 22'h000000,
  parameter logic [SC_W-1:0]  SCALE_STEP  = 17'h00100,
  parameter int               POLL_LIMIT  = 1024,
  parameter int               POLL_GAP    = 16,
  parameter int               ACK_TIMEOUT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [SQ_W-1:0]   sq_target_i,
  input  logic [SQ_W-1:0]   sq_window_i,
  input  logic [GT_W-1:0]   lt_gt_deadband_i,
  input  logic [SC_W-1:0]   scale_init_i,
  input  logic [OF_W-1:0]   offset_init_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [SC_W-1:0]   scale_o,
  output logic [OF_W-1:0]   offset_o,
  output logic [SQ_W-1:0]   sq_last_o,
  output logic [15:0]       iter_count_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADR_W-1:0]  wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(POLL_GAP - 1);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic [SC_W-1:0]   scale_q, scale_d, calc_scale;
  logic [OF_W-1:0]   offset_q, offset_d, calc_offset;
  logic [SQ_W-1:0]   sq_q, sq_d;
  logic [GT_W-1:0]   gt_q, gt_d, lt_q, lt_d;
  logic [15:0]       iter_q, iter_d;
  logic [PCW-1:0]    poll_q, poll_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              stop_q, stop_d;
  logic              err_q, err_d;

  logic              is_bus, req_we, to_hit;
  logic [7:0]        req_off;
  logic [31:0]       req_dat;
  logic [3:0]        req_sel;
  state_e            req_nxt;
  logic              unused_dat;

  assign unused_dat = ^wbm_dat_i[31:SQ_W];

  agc_loop_calc #(
    .SCALE_STEP (SCALE_STEP)
  ) u_calc (
    .sq_i        (sq_q),
    .sq_target_i (sq_target_i),
    .sq_window_i (sq_window_i),
    .gt_i        (gt_q),
    .lt_i        (lt_q),
    .deadband_i  (lt_gt_deadband_i),
    .scale_i     (scale_q),
    .offset_i    (offset_q),
    .scale_o     (calc_scale),
    .offset_o    (calc_offset)
  );

`ifdef AGC_LOOP_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !cyc_q) to_q <= '0;
    else                    to_q <= to_q + 1'b1;
  end

  assign to_hit = cyc_q && (to_q == TW'(ACK_TIMEOUT - 1));
`else
  logic unused_ack_to;
  assign unused_ack_to = (ACK_TIMEOUT > 0);
  assign to_hit        = 1'b0;
`endif

  // Per-state bus request and the state that follows its ack
  always_comb begin
    is_bus  = 1'b1;
    req_we  = 1'b1;
    req_off = OFF_CTRL;
    req_dat = '0;
    req_sel = 4'b0001;
    req_nxt = state_q;
    unique case (state_q)
      S_INIT_RST: begin
        req_dat = CMD_RST;
        req_nxt = S_INIT_SCALE;
      end
      S_INIT_SCALE: begin
        req_off = OFF_SCALE;
        req_dat = 32'(scale_init_i);
        req_sel = 4'b0111;
        req_nxt = S_INIT_OFFSET;
      end
      S_INIT_OFFSET: begin
        req_off = OFF_OFFSET;
        req_dat = 32'(offset_init_i);
        req_nxt = S_INIT_LOAD;
      end
      S_INIT_LOAD, S_WR_LOAD: begin
        req_dat = CMD_LOAD;
        req_sel = 4'b0010;
        req_nxt = (state_q == S_WR_LOAD) ? S_DONE : S_TICK;
      end
      S_TICK: begin
        req_dat = CMD_TICK;
        req_nxt = S_POLL;
      end
      S_POLL: begin
        req_we  = 1'b0;
        req_sel = 4'b1111;
        req_nxt = S_RD_SQ;
      end
      S_RD_SQ, S_RD_GT, S_RD_LT: begin
        req_we  = 1'b0;
        req_sel = 4'b1111;
        unique case (state_q)
          S_RD_SQ: begin req_off = OFF_SQ; req_nxt = S_RD_GT; end
          S_RD_GT: begin req_off = OFF_GT; req_nxt = S_RD_LT; end
          default: begin req_off = OFF_LT; req_nxt = S_CALC;  end
        endcase
      end
      S_WR_SCALE: begin
        req_off = OFF_SCALE;
        req_dat = 32'(scale_q);
        req_sel = 4'b0111;
        req_nxt = S_WR_OFFSET;
      end
      S_WR_OFFSET: begin
        req_off = OFF_OFFSET;
        req_dat = 32'(offset_q);
        req_nxt = S_WR_LOAD;
      end
      default: is_bus = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    scale_d  = scale_q;
    offset_d = offset_q;
    sq_d     = sq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    iter_d   = iter_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_i && !stop_i) begin
          state_d = S_INIT_RST;
          err_d   = 1'b0;
        end
      end
      S_POLL_WAIT: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_POLL;
        end
      end
      S_CALC: begin
        scale_d  = calc_scale;
        offset_d = calc_offset;
        state_d  = S_WR_SCALE;
      end
      S_DONE: begin
        iter_d  = iter_q + 16'd1;
        state_d = (continuous_i && !stop_q && !stop_i) ? S_TICK : S_IDLE;
      end
      default: ;
    endcase

    if (is_bus) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = req_we;
        adr_d = BASE_ADDR + ADR_W'(req_off);
        dat_d = req_dat;
        sel_d = req_sel;
        if (state_q == S_INIT_SCALE)  scale_d  = scale_init_i;
        if (state_q == S_INIT_OFFSET) offset_d = offset_init_i;
      end else if (wbm_err_i || wbm_rty_i) begin
        cyc_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_ERROR;
      end else if (wbm_ack_i) begin
        cyc_d   = 1'b0;
        state_d = req_nxt;
        case (state_q)
          S_TICK:  poll_d = '0;
          S_RD_SQ: sq_d   = wbm_dat_i[SQ_W-1:0];
          S_RD_GT: gt_d   = wbm_dat_i[GT_W-1:0];
          S_RD_LT: lt_d   = wbm_dat_i[GT_W-1:0];
          S_POLL: begin
            if (!wbm_dat_i[CTRL_DONE]) begin
              poll_d = poll_q + 1'b1;
              if (poll_q == POLL_LAST) begin
                err_d   = 1'b1;
                state_d = S_ERROR;
              end else begin
                state_d = S_POLL_WAIT;
              end
            end
          end
          default: ;
        endcase
      end else if (to_hit) begin
        cyc_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_ERROR;
      end
    end

    stop_d = stop_q | stop_i;
    if (state_q == S_IDLE || state_q == S_ERROR || state_d == S_IDLE)
      stop_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      scale_q  <= '0;
      offset_q <= '0;
      sq_q     <= '0;
      gt_q     <= '0;
      lt_q     <= '0;
      iter_q   <= '0;
      poll_q   <= '0;
      gap_q    <= '0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      scale_q  <= scale_d;
      offset_q <= offset_d;
      sq_q     <= sq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      iter_q   <= iter_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign scale_o      = scale_q;
  assign offset_o     = offset_q;
  assign sq_last_o    = sq_q;
  assign iter_count_o = iter_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_sel_o    = sel_q;

endmodule

// File: tb/tb_agc_loop_master.sv
// Bench for agc_loop_master: WB register-target model with a
// scoreboard of expected writes, vector table plus corner sequences.
module tb_agc_loop_master;

  localparam logic [21:0] BASE = 22'h000100;
  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [23:0] sq_target_i = 24'h080000;
  logic [23:0] sq_window_i = 24'h010000;
  logic [20:0] deadband_i = 21'd100;
  logic [16:0] scale_init_i = '0;
  logic [7:0]  offset_init_i = '0;
  logic        busy_o, done_o, err_o;
  logic [16:0] scale_o;
  logic [7:0]  offset_o;
  logic [23:0] sq_last_o;
  logic [15:0] iter_count_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [21:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0;
  logic        s_err = 1'b0;

  always #5 clk = ~clk;

  agc_loop_master #(
    .BASE_ADDR  (BASE),
    .POLL_LIMIT (8),
    .POLL_GAP   (2)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .continuous_i     (continuous_i),
    .sq_target_i      (sq_target_i),
    .sq_window_i      (sq_window_i),
    .lt_gt_deadband_i (deadband_i),
    .scale_init_i     (scale_init_i),
    .offset_init_i    (offset_init_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .scale_o          (scale_o),
    .offset_o         (offset_o),
    .sq_last_o        (sq_last_o),
    .iter_count_o     (iter_count_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_dat_i        (s_dat),
    .wbm_ack_i        (s_ack),
    .wbm_err_i        (s_err),
    .wbm_rty_i        (1'b0)
  );

  typedef struct {
    logic [21:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  typedef struct {
    logic [16:0] sc;
    logic [7:0]  of;
    logic [23:0] sq;
    logic [20:0] gt;
    logic [20:0] lt;
    logic [16:0] esc;
    logic [7:0]  eof;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ctrl_reads = 0;
  int polls_since_tick = 0;
  bit never_done = 0;
  bit err_on_gt = 0;
  logic [23:0] m_sq = '0;
  logic [20:0] m_gt = '0;
  logic [20:0] m_lt = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_wr(logic [7:0] off, logic [31:0] d, logic [3:0] s);
    wr_t w;
    w.adr = BASE + 22'(off);
    w.dat = d;
    w.sel = s;
    exp_q.push_back(w);
  endtask

  task automatic push_init(logic [16:0] sc, logic [7:0] of);
    push_wr(8'h00, 32'h4, 4'b0001);
    push_wr(8'h10, 32'(sc), 4'b0111);
    push_wr(8'h14, 32'(of), 4'b0001);
    push_wr(8'h00, 32'h700, 4'b0010);
  endtask

  task automatic push_iter(logic [16:0] sc, logic [7:0] of);
    push_wr(8'h00, 32'h1, 4'b0001);
    push_wr(8'h10, 32'(sc), 4'b0111);
    push_wr(8'h14, 32'(of), 4'b0001);
    push_wr(8'h00, 32'h700, 4'b0010);
  endtask

  // Register target model: one-cycle ack, done after 2 polls
  always @(negedge clk) begin
    logic [21:0] off;
    wr_t e;
    if (rst) begin
      s_ack = 1'b0;
      s_err = 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o && !s_ack && !s_err) begin
      off = wbm_adr_o - BASE;
      if (wbm_we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got adr %h dat %h required none",
                   wbm_adr_o, wbm_dat_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_adr", 32'(wbm_adr_o), 32'(e.adr));
          chk("wr_dat", wbm_dat_o, e.dat);
          chk("wr_sel", 32'(wbm_sel_o), 32'(e.sel));
        end
        if (off == 22'h0 && wbm_dat_o[0]) polls_since_tick = 0;
        s_ack = 1'b1;
      end else begin
        s_ack = 1'b1;
        case (off)
          22'h00: begin
            s_dat = {30'h0, (!never_done && polls_since_tick >= 2), 1'b0};
            ctrl_reads++;
            polls_since_tick++;
          end
          22'h04: s_dat = {8'hA5, m_sq};
          22'h08: begin
            s_dat = {11'h5AA, m_gt};
            if (err_on_gt) begin
              s_err = 1'b1;
              s_ack = 1'b0;
            end
          end
          22'h0C: s_dat = {11'h3C3, m_lt};
          default: s_dat = 32'hDEADBEEF;
        endcase
      end
    end else begin
      s_ack = 1'b0;
      s_err = 1'b0;
    end
  end

  always @(negedge clk) if (done_o) done_cnt++;

  task automatic do_reset();
    rst = 1'b1;
    start_i = 1'b0;
    stop_i = 1'b0;
    continuous_i = 1'b0;
    never_done = 0;
    err_on_gt = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(done_o), 32'd1);
  endtask

  task automatic load_vec(vec_t v);
    scale_init_i = v.sc;
    offset_init_i = v.of;
    m_sq = v.sq;
    m_gt = v.gt;
    m_lt = v.lt;
  endtask

  initial begin
    int d0, r0, n;
    vecs[0] = '{17'h04000, 8'h00, 24'h100000, 21'd500,  21'd500,  17'h03F00, 8'h00};
    vecs[1] = '{17'h00080, 8'h00, 24'h100000, 21'd500,  21'd500,  17'h00000, 8'h00};
    vecs[2] = '{17'h1FF80, 8'h00, 24'h000000, 21'd500,  21'd500,  17'h1FFFF, 8'h00};
    vecs[3] = '{17'h01000, 8'h05, 24'h080000, 21'd1000, 21'd200,  17'h01000, 8'h04};
    vecs[4] = '{17'h01000, 8'h80, 24'h080000, 21'd1000, 21'd200,  17'h01000, 8'h80};
    vecs[5] = '{17'h01000, 8'h7F, 24'h080000, 21'd200,  21'd1000, 17'h01000, 8'h7F};
    vecs[6] = '{17'h01000, 8'hFE, 24'h090000, 21'd200,  21'd1000, 17'h01000, 8'hFF};
    vecs[7] = '{17'h01000, 8'h10, 24'h06FFFF, 21'd600,  21'd500,  17'h01100, 8'h10};
    vecs[8] = '{17'h01000, 8'h10, 24'h070000, 21'd601,  21'd500,  17'h01000, 8'h0F};

    do_reset();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_scale", 32'(scale_o), 32'd0);
    chk("rst_offset", 32'(offset_o), 32'd0);
    chk("rst_iter", 32'(iter_count_o), 32'd0);
    chk("rst_cyc", 32'(wbm_cyc_o | wbm_stb_o), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_vec(vecs[i]);
      push_init(vecs[i].sc, vecs[i].of);
      push_iter(vecs[i].esc, vecs[i].eof);
      d0 = done_cnt;
      pulse_start();
      wait_done($sformatf("v%0d_done", i));
      @(negedge clk);
      chk($sformatf("v%0d_scale", i), 32'(scale_o), 32'(vecs[i].esc));
      chk($sformatf("v%0d_offset", i), 32'(offset_o), 32'(vecs[i].eof));
      chk($sformatf("v%0d_sq_last", i), 32'(sq_last_o), 32'(vecs[i].sq));
      chk($sformatf("v%0d_iter", i), 32'(iter_count_o), 32'd1);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'd0);
      chk($sformatf("v%0d_pulses", i), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("v%0d_q_empty", i), 32'(exp_q.size()), 32'd0);
    end

    // Poll limit: done never appears
    do_reset();
    load_vec(vecs[0]);
    never_done = 1;
    push_init(vecs[0].sc, vecs[0].of);
    push_wr(8'h00, 32'h1, 4'b0001);
    r0 = ctrl_reads;
    pulse_start();
    n = 0;
    while (!err_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("poll_err", 32'(err_o), 32'd1);
    chk("poll_reads", 32'(ctrl_reads - r0), 32'd8);
    chk("poll_busy", 32'(busy_o), 32'd0);
    chk("poll_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("poll_q_empty", 32'(exp_q.size()), 32'd0);

    // Bus error on the GT read, then recovery via start
    do_reset();
    load_vec(vecs[0]);
    err_on_gt = 1;
    push_init(vecs[0].sc, vecs[0].of);
    push_wr(8'h00, 32'h1, 4'b0001);
    pulse_start();
    n = 0;
    while (!s_err && n < LIMIT) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("berr_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("berr_err", 32'(err_o), 32'd1);
    chk("berr_busy", 32'(busy_o), 32'd0);
    repeat (20) @(negedge clk);
    chk("berr_no_wr", 32'(exp_q.size()), 32'd0);
    chk("berr_scale", 32'(scale_o), 32'h04000);
    err_on_gt = 0;
    push_init(vecs[0].sc, vecs[0].of);
    push_iter(17'h03F00, 8'h00);
    pulse_start();
    chk("berr_clear", 32'(err_o), 32'd0);
    chk("berr_rerun", 32'(busy_o), 32'd1);
    wait_done("berr_done");
    @(negedge clk);
    chk("berr_scale2", 32'(scale_o), 32'h03F00);
    chk("berr_q_empty", 32'(exp_q.size()), 32'd0);

    // Continuous mode, stop during the second poll phase
    do_reset();
    load_vec(vecs[0]);
    continuous_i = 1'b1;
    push_init(vecs[0].sc, vecs[0].of);
    push_iter(17'h03F00, 8'h00);
    push_iter(17'h03E00, 8'h00);
    d0 = done_cnt;
    pulse_start();
    wait_done("cont_done1");
    @(negedge clk);
    n = 0;
    while (!(wbm_cyc_o && !wbm_we_o && wbm_adr_o == BASE) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("cont_poll_seen", 32'(wbm_cyc_o && !wbm_we_o), 32'd1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_done("cont_done2");
    @(negedge clk);
    chk("cont_iter", 32'(iter_count_o), 32'd2);
    repeat (60) @(negedge clk);
    chk("cont_idle", 32'(busy_o), 32'd0);
    chk("cont_pulses", 32'(done_cnt - d0), 32'd2);
    chk("cont_q_empty", 32'(exp_q.size()), 32'd0);
    chk("cont_scale", 32'(scale_o), 32'h03E00);

    // start and stop together: stays idle
    do_reset();
    start_i = 1'b1;
    stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("ss_busy", 32'(busy_o), 32'd0);
    chk("ss_cyc", 32'(wbm_cyc_o), 32'd0);

    // Reset while a cycle is in flight drops cyc at once
    load_vec(vecs[0]);
    push_init(vecs[0].sc, vecs[0].of);
    pulse_start();
    n = 0;
    while (!wbm_cyc_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
